pll_reset_ctrl: RTL and testbench
=================================

# pll_reset_ctrl

Reset sequencer and lock supervisor for the 9.216 MHz video/audio PLL. Runs on the 50 MHz reference clock. Drives the PLL's reset input, synchronizes and deglitches the PLL's `locked` output, and releases the system reset only after lock has been stable for a programmable time. It re-sequences the PLL on lock timeout, lock loss or an explicit restart request.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (1..2^24-1).
- `LOCK_TIMEOUT`, 1000000: cycles to wait for lock before retrying (1..2^24-1).
- `STABLE_CYCLES`, 1024: cycles `locked` must stay continuously high before release (1..2^24-1).
- `MAX_RETRIES`, 4: timeouts tolerated before FAIL; used only when `PLL_FAIL_DETECT_EN` is defined (1..255).

Ports:
- `refclk` in 1: reference clock; the block's only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`; asynchronous to `refclk`.
- `restart` in 1: synchronous request to re-sequence the PLL.
- `pll_rst` out 1: reset to the PLL.
- `sys_rst` out 1: reset to downstream logic; high until lock is stable.
- `lock_lost` out 1: one-cycle pulse when lock drops in RUN.
- `retry_cnt` out 8: number of lock timeouts since `rst`; saturates at 255.
- `pll_fail` out 1: sticky failure flag.

## Operation
- `pll_locked` passes through a 2-flop synchronizer; its output is `locked_s`. Both flops reset to 0.
- One 24-bit cycle counter. It clears on every state entry.
- All outputs are registered and decoded from the next state.
- Priority order: `rst` > `restart` > state transitions.
- Reset values: state PLLRST, counter 0, `pll_rst`=1, `sys_rst`=1, `lock_lost`=0, `retry_cnt`=0, `pll_fail`=0.
- `restart`=1 in any state: go to PLLRST with counter 0. `retry_cnt` is unchanged.

State machine:
- **PLLRST** (`pll_rst`=1, `sys_rst`=1)
  - Counts 0..RST_CYCLES-1.
  - At RST_CYCLES-1, go to WAIT.
- **WAIT** (`pll_rst`=0, `sys_rst`=1)
  - If `locked_s`=1, go to STABLE.
  - Else, at counter LOCK_TIMEOUT-1, increment `retry_cnt` (saturating) and go to PLLRST, or to FAIL (see Configuration).
  - Lock wins if it arrives in the same cycle as the timeout.
- **STABLE** (`pll_rst`=0, `sys_rst`=1)
  - If `locked_s`=0, go to WAIT with counter 0. No retry is counted; the glitch is absorbed.
  - Else, at counter STABLE_CYCLES-1, go to RUN.
- **RUN** (`pll_rst`=0, `sys_rst`=0)
  - If `locked_s`=0, go to PLLRST and assert `lock_lost` for exactly the first PLLRST cycle.
- **FAIL** (`pll_rst`=1, `sys_rst`=1, `pll_fail`=1)
  - Exits only via `rst` or `restart`.
  - `pll_fail` clears on exit.

## Timing
- After the `rst` deassertion edge, `pll_rst` stays high for exactly RST_CYCLES cycles, then goes low.
- Lock rise: if `pll_locked` is first sampled high at edge e, `locked_s` rises at e+1 and `sys_rst` falls at edge e+STABLE_CYCLES+2, provided lock holds throughout.
- Lock fall in RUN: if `pll_locked` is first sampled low at edge e, then at edge e+2:
  - `sys_rst`=1
  - `pll_rst`=1
  - `lock_lost`=1, returning to 0 at e+3.
- Timeout: if WAIT is entered at edge w and lock never arrives, then at edge w+LOCK_TIMEOUT:
  - `pll_rst` rises;
  - `retry_cnt` increments on the same edge.
- `restart` asserted at edge r: `pll_rst`=1 and `sys_rst`=1 from edge r+1.
- `restart` held high keeps the block in PLLRST with the counter at 0.
- A `rst` or `restart` mid-count discards the counter value. There is no partial release.
- `retry_cnt` at 255 stays at 255 on further timeouts.

## Configuration
- Macro: `PLL_FAIL_DETECT_EN`.
- Defined:
  - A WAIT timeout that brings `retry_cnt` to ≥ MAX_RETRIES goes to FAIL instead of PLLRST.
  - `pll_fail` is asserted from that edge.
- Undefined:
  - FAIL state and `MAX_RETRIES` logic are not compiled.
  - Timeouts always go to PLLRST and retry indefinitely.
  - `pll_fail` is tied to 0.

## Test plan
Parameters for all cases: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3.
- **Clean power-up:** release `rst`; raise `pll_locked` 10 cycles later → `pll_rst` is high for 4 cycles, `sys_rst` falls 10 edges after `pll_locked` is first sampled high, `retry_cnt`=0.
- **Glitch in STABLE:** `pll_locked` drops for 1 cycle, 5 cycles after rising → `sys_rst` stays high; release occurs 10 edges after the re-rise sample; `retry_cnt`=0.
- **Lock loss in RUN:** drop `pll_locked` → `lock_lost` is a single 1-cycle pulse 2 edges after the sample, `sys_rst`=1 and `pll_rst`=1 on that edge, `pll_rst` is high for 4 cycles, then normal re-lock.
- **Timeouts with `PLL_FAIL_DETECT_EN`:** hold `pll_locked`=0 → `retry_cnt` goes 1, 2, 3 at 32-cycle WAIT intervals, then FAIL with `pll_fail`=1 and `pll_rst`=1 held; a `restart` pulse clears `pll_fail`, and `retry_cnt` stays 3.
- **Timeouts without the macro:** hold `pll_locked`=0 for 300 timeouts → `retry_cnt` saturates at 255, `pll_fail` stays 0, `pll_rst` keeps pulsing.
- **`restart` in RUN and same-cycle priority:** `restart` in RUN → `sys_rst`=1 next edge, `lock_lost` stays 0; lock arriving on the exact timeout cycle → STABLE, `retry_cnt` not incremented.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for a stable lock, then releases sys_rst.
// Optional lock-failure detection (FAIL state, MAX_RETRIES) is compiled in with `define PLL_FAIL_DETECT_EN.
module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_lost,
  output logic [7:0] retry_cnt,
  output logic       pll_fail
);

  localparam int unsigned CW = 24;
  localparam logic [CW-1:0] RstLast    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] StableLast = CW'(STABLE_CYCLES - 1);

  if (RST_CYCLES == 0 || LOCK_TIMEOUT == 0 || STABLE_CYCLES == 0 ||
      RST_CYCLES >= (1 << CW) || LOCK_TIMEOUT >= (1 << CW) || STABLE_CYCLES >= (1 << CW) ||
      MAX_RETRIES == 0 || MAX_RETRIES > 255) begin : g_param_err
    $error("pll_reset_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_RUN
`ifdef PLL_FAIL_DETECT_EN
    , S_FAIL
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, locked_s_q;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          lock_lost_q, lock_lost_d;
  logic [7:0]    retry_q, retry_d;
  logic [7:0]    retry_inc;

  assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

  // Two-flop synchronizer for the asynchronous lock indicator
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    unique case (state_q)
      S_PLLRST: begin
        if (cnt_q == RstLast) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (locked_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TimeoutLast) begin
          retry_d = retry_inc;
`ifdef PLL_FAIL_DETECT_EN
          state_d = (retry_inc >= 8'(MAX_RETRIES)) ? S_FAIL : S_PLLRST;
`else
          state_d = S_PLLRST;
`endif
        end
      end
      S_STABLE: begin
        if (!locked_s_q)               state_d = S_WAIT;
        else if (cnt_q == StableLast) state_d = S_RUN;
      end
      S_RUN: begin
        if (!locked_s_q) begin
          state_d     = S_PLLRST;
          lock_lost_d = 1'b1;
        end
      end
`ifdef PLL_FAIL_DETECT_EN
      S_FAIL: state_d = S_FAIL;
`endif
      default: state_d = S_PLLRST;
    endcase

    // Restart overrides any transition and leaves the retry count alone
    if (restart) begin
      state_d     = S_PLLRST;
      retry_d     = retry_q;
      lock_lost_d = 1'b0;
    end

    cnt_d = (restart || (state_d != state_q)) ? '0 : cnt_q + CW'(1);

    sys_rst_d = (state_d != S_RUN);
`ifdef PLL_FAIL_DETECT_EN
    pll_rst_d = (state_d == S_PLLRST) || (state_d == S_FAIL);
`else
    pll_rst_d = (state_d == S_PLLRST);
`endif
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_PLLRST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      lock_lost_q <= 1'b0;
      retry_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
    end
  end

`ifdef PLL_FAIL_DETECT_EN
  logic pll_fail_q;

  always_ff @(posedge refclk) begin
    if (rst) pll_fail_q <= 1'b0;
    else     pll_fail_q <= (state_d == S_FAIL);
  end

  assign pll_fail = pll_fail_q;
`else
  assign pll_fail = 1'b0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: vector table plus timeout sequences, expectations queued per vector.
module tb_pll_reset_ctrl;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 32;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned MAX_RETRIES   = 3;
`ifdef PLL_FAIL_DETECT_EN
  localparam bit FAIL_EN = 1'b1;
`else
  localparam bit FAIL_EN = 1'b0;
`endif

  typedef struct packed {
    logic       prst;
    logic       srst;
    logic       ll;
    logic [7:0] rc;
    logic       fail;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        restart;
    logic        lk;
    int unsigned n;
    exp_t        exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, pll_locked, restart;
  logic       pll_rst, sys_rst, lock_lost, pll_fail;
  logic [7:0] retry_cnt;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  pll_reset_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .refclk    (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt),
    .pll_fail  (pll_fail)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic rs, logic lk, int unsigned n,
                              logic pr, logic sr, logic ll, logic [7:0] rc, logic f);
    vec_t v;
    v.rst = r; v.restart = rs; v.lk = lk; v.n = n;
    v.exp = '{prst: pr, srst: sr, ll: ll, rc: rc, fail: f};
    return v;
  endfunction

  // Drive inputs, queue the expectation, advance n edges, compare on the falling edge
  task automatic apply(input vec_t v, input string name);
    exp_t got, e;
    rst = v.rst; restart = v.restart; pll_locked = v.lk;
    exp_q.push_back(v.exp);
    repeat (v.n) @(posedge clk);
    @(negedge clk);
    got = {pll_rst, sys_rst, lock_lost, retry_cnt, pll_fail};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL %s: got pll_rst=%b sys_rst=%b lock_lost=%b retry=%0d fail=%b, want pll_rst=%b sys_rst=%b lock_lost=%b retry=%0d fail=%b",
               name, got.prst, got.srst, got.ll, got.rc, got.fail, e.prst, e.srst, e.ll, e.rc, e.fail);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    int unsigned nto;
    logic [7:0]  prev_rc, cur_rc;
    logic        to_fail;

    rst = 1'b1; restart = 1'b0; pll_locked = 1'b0;

    // Clean power-up; lock sampled at edge 11, release at edge 21
    vecs.push_back(mk(1,0,0, 3, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 3, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 6, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 9, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,0,0,0,0));
    // Lock loss in RUN: drop sampled at edge 27, reaction at edge 29
    vecs.push_back(mk(0,0,1, 5, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1, 1,1,1,0,0));
    vecs.push_back(mk(0,0,0, 1, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 2, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1,10, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,0,0,0,0));
    // Restart in RUN, held, then released with lock already present
    vecs.push_back(mk(0,1,1, 1, 1,1,0,0,0));
    vecs.push_back(mk(0,1,1,10, 1,1,0,0,0));
    vecs.push_back(mk(0,0,1, 3, 1,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 8, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,0,0,0,0));
    // Glitch in STABLE: one-cycle drop sampled at edge 16, re-rise at 17, release at 27
    vecs.push_back(mk(1,0,0, 2, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0,10, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 5, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1,10, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,0,0,0,0));
    // Lock arrives exactly on the timeout edge (36): lock wins
    vecs.push_back(mk(1,0,0, 2, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0,33, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 2, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 7, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,0,0,0,0));
    // Lock one edge too late: timeout, retry counted, then re-lock and restart
    vecs.push_back(mk(1,0,0, 2, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0,34, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 1, 1,1,0,1,0));
    vecs.push_back(mk(0,0,1, 3, 1,1,0,1,0));
    vecs.push_back(mk(0,0,1, 1, 0,1,0,1,0));
    vecs.push_back(mk(0,0,1, 8, 0,1,0,1,0));
    vecs.push_back(mk(0,0,1, 1, 0,0,0,1,0));
    vecs.push_back(mk(0,1,1, 1, 1,1,0,1,0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Repeated timeouts with lock held low: one every 36 edges
    apply(mk(1,0,0, 2, 1,1,0,0,0), "to_reset");
    nto = FAIL_EN ? MAX_RETRIES : 300;
    for (int k = 1; k <= int'(nto); k++) begin
      prev_rc = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
      cur_rc  = (k > 255) ? 8'd255 : 8'(k);
      to_fail = FAIL_EN && (k == int'(MAX_RETRIES));
      apply(mk(0,0,0,35, 0,1,0,prev_rc,0), $sformatf("to%0d_before", k));
      apply(mk(0,0,0, 1, 1,1,0,cur_rc,to_fail), $sformatf("to%0d_edge", k));
    end

    if (FAIL_EN) begin
      apply(mk(0,0,0,50, 1,1,0,8'(MAX_RETRIES),1), "fail_hold");
      apply(mk(0,1,0, 1, 1,1,0,8'(MAX_RETRIES),0), "fail_restart");
      apply(mk(0,0,0, 3, 1,1,0,8'(MAX_RETRIES),0), "fail_pllrst");
      apply(mk(0,0,0, 1, 0,1,0,8'(MAX_RETRIES),0), "fail_wait");
    end else begin
      apply(mk(0,0,0,35, 0,1,0,255,0), "sat_before");
      apply(mk(0,0,0, 1, 1,1,0,255,0), "sat_edge");
    end

    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
